mysystem_pio_out: RTL and testbench

MYSYSTEM_PIO_OUT -- requirements
Module: mysystem_pio_out

---
 rtl/mysystem_pio_out_pkg.sv | 12 +
 rtl/mysystem_pio_out_pulse_timer.sv | 33 +++
 rtl/mysystem_pio_out.sv | 95 +++++++++
 tb/tb_mysystem_pio_out.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mysystem_pio_out_pkg.sv
// Shared constants and types for the PIO output block: register word addresses
// and the pulse counter type.
package mysystem_pio_out_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_PULSE = 2'd1;
    localparam logic [1:0] ADDR_SET   = 2'd2;
    localparam logic [1:0] ADDR_CLR   = 2'd3;

    typedef logic [15:0] pulse_cnt_t;

endpackage

// File: rtl/mysystem_pio_out_pulse_timer.sv
// Pulse down-counter: load to PULSE_CYCLES, cancel to zero, otherwise count down
// and hold at zero. active is high while the count is nonzero.
module mysystem_pio_pulse_timer
    import mysystem_pio_out_pkg::*;
#(
    parameter int PULSE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       cancel,
    output pulse_cnt_t count,
    output logic       active
);

    localparam pulse_cnt_t LOAD_VALUE = pulse_cnt_t'(PULSE_CYCLES);

    // Reload wins over both cancel and the ongoing decrement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VALUE;
        end else if (cancel) begin
            count <= '0;
        end else if (count != '0) begin
            count <= count - pulse_cnt_t'(1);
        end
    end

    assign active = (count != '0);

endmodule

// File: rtl/mysystem_pio_out.sv
// Avalon-MM PIO output port with a timed pulse register.
// Optional set/clear registers at addresses 2/3 are built when PIO_OUT_SETCLR_EN is defined.
module mysystem_pio_out
    import mysystem_pio_out_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int               PULSE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] pulse_mask;
    logic [WIDTH-1:0] wd;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             pulse_load;
    logic             pulse_cancel;
    logic             pulse_active;
    pulse_cnt_t       pulse_cnt;
    logic             unused_wd;

    assign wr_en        = chipselect && !write_n;
    assign wd           = writedata[WIDTH-1:0];
    assign unused_wd    = ^writedata;
    assign pulse_load   = wr_en && (address == ADDR_PULSE) && (wd != '0);
    assign pulse_cancel = wr_en && (address == ADDR_PULSE) && (wd == '0);

    mysystem_pio_pulse_timer #(
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_pulse_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pulse_load),
        .cancel  (pulse_cancel),
        .count   (pulse_cnt),
        .active  (pulse_active)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA: data_reg <= wd;
`ifdef PIO_OUT_SETCLR_EN
                ADDR_SET:  data_reg <= data_reg | wd;
                ADDR_CLR:  data_reg <= data_reg & ~wd;
`endif
                default:   data_reg <= data_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_mask <= '0;
        end else if (pulse_load) begin
            pulse_mask <= wd;
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:  rd_next[WIDTH-1:0] = data_reg;
            ADDR_PULSE: rd_next[15:0]      = pulse_cnt;
`ifdef PIO_OUT_SETCLR_EN
            ADDR_SET,
            ADDR_CLR:   rd_next[WIDTH-1:0] = data_reg;
`endif
            default:    rd_next = '0;
        endcase
    end

    // Read data is refreshed every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign out_port = data_reg | (pulse_active ? pulse_mask : '0);

endmodule

// File: tb/tb_mysystem_pio_out.sv
// Scoreboard bench for mysystem_pio_out: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_mysystem_pio_out;

    localparam int KIND_OUT = 0;
    localparam int KIND_RD  = 1;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t q[$];

    mysystem_pio_out #(
        .WIDTH        (8),
        .RESET_VALUE  (8'hA5),
        .PULSE_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                logic [31:0] act;
                act = (q[i].kind == KIND_OUT) ? {24'h0, out_port} : readdata;
                n_cmp++;
                if (act !== q[i].val) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d: %s got %h, expected %h", q[i].name, cyc,
                             (q[i].kind == KIND_OUT) ? "out_port" : "readdata", act, q[i].val);
                end
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: expectation for cyc %0d never sampled (now %0d)",
                         q[i].name, q[i].cyc, cyc);
                q.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dc, input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + dc;
        e.kind = kind;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        logic setclr;
`ifdef PIO_OUT_SETCLR_EN
        setclr = 1'b1;
`else
        setclr = 1'b0;
`endif
        n_cmp      = 0;
        n_bad      = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (2) step();

        // Reset state
        expect_at(0, KIND_OUT, 32'hA5, "rst_out");
        expect_at(0, KIND_RD,  32'h0,  "rst_rd");
        step();

        // Release and write on the very first edge
        reset_n = 1'b1;
        expect_at(1, KIND_RD,  32'hA5, "rd_reset_val");
        expect_at(1, KIND_OUT, 32'h78, "data_out");
        expect_at(2, KIND_RD,  32'h78, "data_rd");
        bus_write(2'd0, 32'h1234_5678);
        step();

        // Unqualified writes are ignored
        expect_at(1, KIND_OUT, 32'h78, "cs_low_ignored");
        address = 2'd0; writedata = 32'hFF; chipselect = 1'b0; write_n = 1'b0;
        step();
        expect_at(1, KIND_OUT, 32'h78, "wn_high_ignored");
        chipselect = 1'b1; write_n = 1'b1;
        step();
        chipselect = 1'b0;

        // Basic pulse of 16 cycles with countdown readback
        bus_write(2'd0, 32'h0);
        for (int k = 1; k <= 16; k++) expect_at(k, KIND_OUT, 32'h01, "pulse_on");
        expect_at(17, KIND_OUT, 32'h00, "pulse_off");
        expect_at(2,  KIND_RD,  32'd16, "cnt_16");
        expect_at(3,  KIND_RD,  32'd15, "cnt_15");
        expect_at(17, KIND_RD,  32'd1,  "cnt_1");
        expect_at(18, KIND_RD,  32'd0,  "cnt_0");
        bus_write(2'd1, 32'h01);
        repeat (18) step();

        // Retrigger at pulse cycle 10
        expect_at(10, KIND_OUT, 32'h01, "retrig_before");
        expect_at(11, KIND_OUT, 32'h02, "retrig_first");
        expect_at(26, KIND_OUT, 32'h02, "retrig_last");
        expect_at(27, KIND_OUT, 32'h00, "retrig_end");
        expect_at(12, KIND_RD,  32'd16, "retrig_reload");
        bus_write(2'd1, 32'h01);
        repeat (9) step();
        bus_write(2'd1, 32'h02);
        repeat (17) step();

        // Cancel with zero mask
        expect_at(3, KIND_OUT, 32'h04, "cancel_before");
        expect_at(4, KIND_OUT, 32'h00, "cancel_out");
        expect_at(5, KIND_RD,  32'd0,  "cancel_cnt");
        bus_write(2'd1, 32'h04);
        repeat (2) step();
        bus_write(2'd1, 32'h00);
        repeat (2) step();

        // DATA write on the expiry edge
        expect_at(16, KIND_OUT, 32'h01, "collide_last");
        expect_at(17, KIND_OUT, 32'h80, "collide_data");
        bus_write(2'd1, 32'h01);
        repeat (15) step();
        bus_write(2'd0, 32'h80);
        repeat (2) step();

        // Reset mid-pulse
        expect_at(4, KIND_OUT, 32'h82, "mid_pulse");
        bus_write(2'd1, 32'h02);
        repeat (4) step();
        reset_n = 1'b0;
        expect_at(0, KIND_OUT, 32'hA5, "rst_mid_out");
        expect_at(0, KIND_RD,  32'h0,  "rst_mid_rd");
        repeat (2) step();
        reset_n = 1'b1;
        address = 2'd1;
        expect_at(1, KIND_OUT, 32'hA5, "rst_rel_out");
        expect_at(3, KIND_OUT, 32'hA5, "no_resume");
        expect_at(1, KIND_RD,  32'h0,  "rst_cnt");
        repeat (4) step();

        // Set/clear registers
        bus_write(2'd0, 32'hF0);
        expect_at(1, KIND_OUT, setclr ? 32'hFF : 32'hF0, "set_out");
        bus_write(2'd2, 32'h0F);
        expect_at(1, KIND_OUT, setclr ? 32'h7E : 32'hF0, "clr_out");
        bus_write(2'd3, 32'h81);
        address = 2'd2;
        expect_at(1, KIND_RD, setclr ? 32'h7E : 32'h0, "addr2_rd");
        repeat (2) step();

        for (int i = 0; i < 50 && q.size() > 0; i++) step();
        while (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation for cyc %0d left unchecked", q[0].name, q[0].cyc);
            void'(q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
